// File: rtl/enc_gray_pkg.sv
// Shared types and the binary-to-Gray helper for the enc_gray_arb encode service.
package enc_gray_pkg;

    localparam int ENC_WIDTH_DEFAULT = 10;
    localparam int ENC_MAX_WIDTH     = 32;
    localparam int ENC_MAX_ID_W      = 4;

    typedef logic [ENC_MAX_ID_W-1:0] req_id_t;

    // Operates at the widest supported width; callers zero-extend and truncate.
    function automatic logic [ENC_MAX_WIDTH-1:0] bin2gray(input logic [ENC_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/enc_gray_arb_if.sv
// Requester and result handshake bundle for enc_gray_arb.
interface enc_gray_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 10
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_bin;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_gray;
    logic [ID_W-1:0]          out_id;

    modport master (
        output req_valid, req_bin, out_ready,
        input  req_ready, out_valid, out_gray, out_id
    );

    modport slave (
        input  req_valid, req_bin, out_ready,
        output req_ready, out_valid, out_gray, out_id
    );

endinterface

// File: rtl/gray_rr_arbiter.sv
// Round-robin grant search starting at a rotating pointer, plus the pointer register.
module gray_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               slot_free_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] cand;
    logic            found;

    // Walk upward from the pointer with wrap-around; the first valid requester wins.
    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(ptr_q) + k >= NUM_REQ) begin
                cand = ID_W'(int'(ptr_q) + k - NUM_REQ);
            end else begin
                cand = ID_W'(int'(ptr_q) + k);
            end
            if (!found && req_valid_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (found && slot_free_i) begin
            grant_o = NUM_REQ'(1) << grant_idx_o;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (grant_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/enc_gray_arb.sv
// Shared binary-to-Gray encoder: round-robin pick of one requester per cycle into a single result slot.
module enc_gray_arb
    import enc_gray_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = ENC_WIDTH_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    enc_gray_arb_if.slave  bus,
    output logic [15:0]    grant_cnt
);

    logic               slotFree;
    logic               transfer;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;
    logic [WIDTH-1:0]   grantBin;

    logic               outValid_q, outValid_d;
    logic [WIDTH-1:0]   outGray_q, outGray_d;
    logic [ID_W-1:0]    outId_q, outId_d;
    logic [15:0]        grantCnt_q, grantCnt_d;

    // The slot accepts a new result when empty or when its current one drains this cycle.
    assign slotFree = !rst && (!outValid_q || bus.out_ready);
    assign transfer = |(grant & bus.req_valid);
    assign grantBin = bus.req_bin[int'(grantIdx)*WIDTH +: WIDTH];

    gray_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (bus.req_valid),
        .slot_free_i (slotFree),
        .advance_i   (transfer),
        .grant_o     (grant),
        .grant_idx_o (grantIdx)
    );

    always_comb begin
        outValid_d = outValid_q;
        outGray_d  = outGray_q;
        outId_d    = outId_q;
        grantCnt_d = grantCnt_q;
        if (transfer) begin
            outValid_d = 1'b1;
            outGray_d  = WIDTH'(bin2gray(ENC_MAX_WIDTH'(grantBin)));
            outId_d    = grantIdx;
            grantCnt_d = grantCnt_q + 16'd1;
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outGray_q  <= '0;
            outId_q    <= '0;
            grantCnt_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            outGray_q  <= outGray_d;
            outId_q    <= outId_d;
            grantCnt_q <= grantCnt_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = outValid_q;
    assign bus.out_gray  = outGray_q;
    assign bus.out_id    = outId_q;
    assign grant_cnt     = grantCnt_q;

endmodule

// File: tb/tb_enc_gray_arb.sv
// Scoreboard bench for enc_gray_arb: reference arbiter model plus directed scenario tasks.
module tb_enc_gray_arb;

    localparam int NREQ = 4;
    localparam int W    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] grant_cnt;

    always #5 clk = ~clk;

    enc_gray_arb_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus();

    enc_gray_arb #(.NUM_REQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_cnt (grant_cnt)
    );

    typedef struct packed {
        logic [W-1:0] gray;
        logic [1:0]   id;
    } result_t;

    int      checks = 0;
    int      errors = 0;
    result_t scoreboard[$];

    bit          armed = 1'b0;
    logic        expValid;
    int          expPtr;
    logic [15:0] expCnt;
    logic        nextValid;
    int          nextPtr;
    logic [15:0] nextCnt;

    // Adjacent-bit XOR form, deliberately different from the shift form used in the design.
    function automatic logic [W-1:0] refGray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    // Reference model: predicts the grant, pushes the expected result, pops on each drain.
    always @(negedge clk) begin
        logic [NREQ-1:0] expReady;
        logic            slotOpen;
        int              win;
        int              j;
        result_t         exp;
        result_t         item;
        if (armed) begin
            slotOpen = !rst && (!expValid || bus.out_ready);
            win      = -1;
            if (slotOpen) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (expPtr + k) % NREQ;
                    if (win < 0 && bus.req_valid[j]) win = j;
                end
            end
            expReady = (win >= 0) ? (NREQ'(1) << win) : '0;
            checks++;
            if (bus.req_ready !== expReady) begin
                errors++;
                $display("[TB] FAIL sb_req_ready: got %b expected %b", bus.req_ready, expReady);
            end
            checks++;
            if (bus.out_valid !== expValid) begin
                errors++;
                $display("[TB] FAIL sb_out_valid: got %b expected %b", bus.out_valid, expValid);
            end
            checks++;
            if (grant_cnt !== expCnt) begin
                errors++;
                $display("[TB] FAIL sb_grant_cnt: got %0d expected %0d", grant_cnt, expCnt);
            end
            if (!rst && expValid && bus.out_ready) begin
                checks++;
                if (scoreboard.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_underflow: got drain expected no result");
                end else begin
                    exp = scoreboard.pop_front();
                    if (bus.out_gray !== exp.gray || bus.out_id !== exp.id) begin
                        errors++;
                        $display("[TB] FAIL sb_result: got gray %h id %0d expected gray %h id %0d",
                                 bus.out_gray, bus.out_id, exp.gray, exp.id);
                    end
                end
            end
            nextValid = expValid;
            nextPtr   = expPtr;
            nextCnt   = expCnt;
            if (win >= 0) begin
                item.gray = refGray(bus.req_bin[win*W +: W]);
                item.id   = 2'(win);
                scoreboard.push_back(item);
                nextValid = 1'b1;
                nextPtr   = (win + 1) % NREQ;
                nextCnt   = expCnt + 16'd1;
            end else if (expValid && bus.out_ready) begin
                nextValid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b1;
            expValid <= 1'b0;
            expPtr   <= 0;
            expCnt   <= '0;
            scoreboard.delete();
        end else if (armed) begin
            expValid <= nextValid;
            expPtr   <= nextPtr;
            expCnt   <= nextCnt;
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_bin   = '0;
        bus.out_ready = 1'b0;
        waitCycle();
        waitCycle();
        bus.req_valid = '1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_gray !== 10'h000 || bus.out_id !== 2'd0 || grant_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v%b g%h id%0d cnt%0d expected all zero",
                     bus.out_valid, bus.out_gray, bus.out_id, grant_cnt);
        end
        waitCycle();
        rst           = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_encode();
        logic [W-1:0] vin [4] = '{10'h2A5, 10'h3FF, 10'h001, 10'h200};
        logic [W-1:0] vexp[4] = '{10'h3F7, 10'h200, 10'h001, 10'h300};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_bin[0 +: W] = vin[i];
            bus.req_valid       = 4'b0001;
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL encode_ready: got %b expected 0001", bus.req_ready);
            end
            waitCycle();
            bus.req_valid = '0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_gray !== vexp[i] || bus.out_id !== 2'd0) begin
                errors++;
                $display("[TB] FAIL encode_value: got v%b g%h id%0d expected v1 g%h id0",
                         bus.out_valid, bus.out_gray, bus.out_id, vexp[i]);
            end
        end
        checks++;
        if (grant_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL encode_count: got %0d expected 4", grant_cnt);
        end
    endtask

    task automatic test_fairness();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_bin[i*W +: W] = W'($urandom);
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (!$onehot(bus.req_ready) || bus.req_ready !== (NREQ'(1) << seq[k])) begin
                errors++;
                $display("[TB] FAIL fair_ready: got %b expected one-hot bit %0d", bus.req_ready, seq[k]);
            end
            waitCycle();
            checks++;
            if (bus.out_id !== 2'(seq[k])) begin
                errors++;
                $display("[TB] FAIL fair_id: got %0d expected %0d", bus.out_id, seq[k]);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_sparse();
        bus.req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL sparse_first: got %b expected 1000", bus.req_ready);
        end
        waitCycle();
        checks++;
        if (bus.out_id !== 2'd3) begin
            errors++;
            $display("[TB] FAIL sparse_id3: got %0d expected 3", bus.out_id);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL sparse_second: got %b expected 0001", bus.req_ready);
        end
        waitCycle();
        checks++;
        if (bus.out_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL sparse_id0: got %0d expected 0", bus.out_id);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v0 = W'($urandom);
        logic [W-1:0] v1 = W'($urandom);
        bus.req_bin[0*W +: W] = v0;
        bus.req_bin[1*W +: W] = v1;
        bus.req_bin[2*W +: W] = W'($urandom);
        bus.req_valid = 4'b0001;
        bus.out_ready = 1'b1;
        waitCycle();
        bus.req_valid = 4'b0110;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1 ||
                bus.out_gray !== refGray(v0) || bus.out_id !== 2'd0) begin
                errors++;
                $display("[TB] FAIL bp_hold: got rdy%b v%b g%h id%0d expected rdy0000 v1 g%h id0",
                         bus.req_ready, bus.out_valid, bus.out_gray, bus.out_id, refGray(v0));
            end
            waitCycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 0010", bus.req_ready);
        end
        waitCycle();
        bus.req_valid = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_gray !== refGray(v1)) begin
            errors++;
            $display("[TB] FAIL bp_refill: got v%b id%0d g%h expected v1 id1 g%h",
                     bus.out_valid, bus.out_id, bus.out_gray, refGray(v1));
        end
        waitCycle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_id !== 2'd1 || bus.out_gray !== refGray(v1)) begin
            errors++;
            $display("[TB] FAIL bp_drain: got v%b id%0d g%h expected v0 id1 g%h",
                     bus.out_valid, bus.out_id, bus.out_gray, refGray(v1));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NREQ; i++) bus.req_bin[i*W +: W] = W'($urandom);
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        waitCycle();
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        waitCycle();
        rst           = 1'b0;
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || grant_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got v%b cnt%0d expected v0 cnt0", bus.out_valid, grant_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL midrst_grant: got %b expected 0010", bus.req_ready);
        end
        waitCycle();
        bus.req_valid = '0;
        checks++;
        if (bus.out_id !== 2'd1 || grant_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midrst_first: got id%0d cnt%0d expected id1 cnt1", bus.out_id, grant_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        int remaining = 65536 - int'(expCnt);
        bit glitch    = 1'b0;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int c = 0; c < remaining; c++) begin
            waitCycle();
            if (bus.out_valid !== 1'b1) glitch = 1'b1;
        end
        checks++;
        if (grant_cnt !== 16'd0 || glitch) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got cnt%0d glitch%0d expected cnt0 glitch0", grant_cnt, glitch);
        end
        waitCycle();
        bus.req_valid = '0;
        checks++;
        if (grant_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL wrap_after: got %0d expected 1", grant_cnt);
        end
        waitCycle();
        waitCycle();
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d entries expected 0", scoreboard.size());
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_fairness();
        test_sparse();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
